instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Instruction-fetch sequencer for the pipelined 64-bit ARM CPU. It owns the program counter, drives the combinational instruction ROM address, and captures `{pc, instruction}` into the IF/ID pipeline register. It applies stall, branch-redirect/squash and, optionally, bounds/alignment fault policing. It sits between the instruction ROM and the decode stage; the hazard unit and the branch-resolution stage feed it control.

## Interface
- `MEM_SIZE`, 1024: instruction ROM size in bytes; power of two, > 4.
- `RESET_PC`, 64'h0: PC loaded on reset; word-aligned.
- `clk` input 1: single clock, all state on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `stall` input 1: decode not ready; hold PC and IF/ID.
- `br_taken` input 1: taken branch resolved this cycle; redirect and squash.
- `br_target` input 64: byte address of the branch target.
- `imem_addr` output 64: ROM byte address; equals current PC, combinational from the PC register.
- `imem_instr` input 32: ROM read data for `imem_addr`, valid in the same cycle.
- `if_valid` output 1: IF/ID holds a live instruction.
- `if_pc` output 64: PC of the IF/ID instruction.
- `if_instr` output 32: IF/ID instruction word.
- `fetch_count` output 32: number of instructions captured into IF/ID.
- `fault` output 1: sticky fetch fault; present only meaningfully with `FETCH_BOUNDS_CHECK_EN`.

## Operation
- States: RUN and HALT. HALT exists only with the macro. Reset enters RUN.
- Reset values: PC=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_instr`=32'h0, `fetch_count`=0, `fault`=0.
- RUN, per edge, by priority:
  1. `br_taken`: PC <= `br_target`; `if_valid` <= 0; `if_pc`/`if_instr` hold. `fetch_count` is unchanged.
  2. `stall`: PC, `if_valid`, `if_pc`, `if_instr` and `fetch_count` all hold.
  3. Fault check (macro only): fires if PC[1:0] != 0 or PC+3 >= `MEM_SIZE`. Then `fault` <= 1, `if_valid` <= 0, PC holds, state -> HALT.
  4. Otherwise (capture): `if_pc` <= PC, `if_instr` <= `imem_instr`, `if_valid` <= 1, PC <= PC+4, `fetch_count` <= `fetch_count`+1.
- `br_taken` together with `stall`: the branch wins; the squash of the older IF/ID entry is mandatory.
- PC arithmetic is unsigned 64-bit. PC+4 wraps modulo 2^64. `fetch_count` wraps modulo 2^32.
- Without the macro, out-of-range or misaligned PCs are passed to the ROM unchanged. The ROM returns X, and that X is captured as-is.
- HALT: `if_valid`=0, PC frozen, `fault`=1. `stall` and `br_taken` are ignored. Only `reset` exits HALT.
- `br_target` is not checked at redirect time. A bad target faults on the following capture attempt.

## Timing
- Fetch latency is 1 cycle: the instruction at PC is visible on `if_*` after the next rising edge with no stall and no branch.
- First valid instruction: the first edge after `reset` deasserts gives `if_valid`=1, `if_pc`=`RESET_PC`.
- Branch penalty: the redirect edge produces one bubble, and the target instruction appears at the edge after.
- `reset` asserted mid-operation: all state returns to reset values immediately, without waiting for an edge. Any in-flight IF/ID entry is lost.
- `imem_addr` changes only after `clk` edges or `reset`. It has no combinational path from `stall`, `br_taken` or `br_target`.

## Configuration
- `FETCH_BOUNDS_CHECK_EN` defined: alignment/bounds check active, HALT state present, `fault` is driven as described above.
- Not defined: no check and no HALT state; `fault` is tied to 0. Logic is otherwise identical.

## Test plan
- Reset, then 4 free-running cycles with the ROM holding A,B,C,D at 0,4,8,12 -> `if_pc` = 0,4,8,12; `if_instr` = A..D; `fetch_count`=4.
- Stall for 3 cycles while `if_pc`=8 -> `if_pc`=8 and `imem_addr`=12 held, `fetch_count` frozen; the capture of 12 occurs on the first unstalled edge.
- `br_taken`=1, `br_target`=0x40, with `stall`=1 in the same cycle -> next edge gives `if_valid`=0, `imem_addr`=0x40; the edge after gives `if_pc`=0x40, `if_valid`=1.
- Macro on, `br_target`=0x3FE -> redirect, then `fault`=1, `if_valid`=0 and PC stuck at 0x3FE. Later branches and stalls are ignored until `reset`. Repeat with target 0x3FC for `MEM_SIZE`=1024: fetch from 0x3FC succeeds, then PC 0x400 faults.
- Macro off, same 0x3FE target -> `fault` stays 0, `if_valid`=1 and capture proceeds.
- Assert `reset` asynchronously between edges mid-run -> `if_valid`=0, `imem_addr`=`RESET_PC` and `fetch_count`=0 with no clock edge; normal fetch resumes from `RESET_PC` after release.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// instr_fetch_ctrl_if: control inputs, instruction ROM port and IF/ID outputs of the fetch stage
interface instr_fetch_ctrl_if;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_count;
    logic        fault;
    modport master (
        input  stall, br_taken, br_target, imem_instr,
        output imem_addr, if_valid, if_pc, if_instr, fetch_count, fault
    );
    modport slave (
        output stall, br_taken, br_target, imem_instr,
        input  imem_addr, if_valid, if_pc, if_instr, fetch_count, fault
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer and IF/ID capture; FETCH_BOUNDS_CHECK_EN adds alignment/bounds faulting and HALT
module instr_fetch_ctrl #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic clk,
    input logic reset,
    instr_fetch_ctrl_if.master bus
);
`ifdef FETCH_BOUNDS_CHECK_EN
    typedef enum logic {RUN, HALT} state_t;
`else
    typedef enum logic {RUN} state_t;
`endif
    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        if_valid_q, if_valid_d;
    logic        fault_q, fault_d;
    if (MEM_SIZE <= 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0 || RESET_PC[1:0] != 2'b00) begin : g_bad_params
        $error("instr_fetch_ctrl: MEM_SIZE must be a power of two > 4 and RESET_PC word-aligned");
    end
`ifdef FETCH_BOUNDS_CHECK_EN
    logic bad_pc;
    assign bad_pc = (pc_q[1:0] != 2'b00) || (pc_q + 64'd3 >= 64'(MEM_SIZE));
`endif
    assign bus.imem_addr   = pc_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_instr    = if_instr_q;
    assign bus.fetch_count = fetch_count_q;
    assign bus.fault       = fault_q;
    // State and IF/ID register, cleared asynchronously on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 64'h0;
            if_instr_q    <= 32'h0;
            fetch_count_q <= 32'h0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            fetch_count_q <= fetch_count_d;
            fault_q       <= fault_d;
        end
    end
    // Next state: branch beats stall, stall beats fault check, otherwise capture and advance
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        fetch_count_d = fetch_count_q;
        fault_d       = fault_q;
        if (state_q == RUN) begin
            if (bus.br_taken) begin
                pc_d       = bus.br_target;
                if_valid_d = 1'b0;
            end else if (!bus.stall) begin
`ifdef FETCH_BOUNDS_CHECK_EN
                if (bad_pc) begin
                    fault_d    = 1'b1;
                    if_valid_d = 1'b0;
                    state_d    = HALT;
                end else
`endif
                begin
                    if_pc_d       = pc_q;
                    if_instr_d    = bus.imem_instr;
                    if_valid_d    = 1'b1;
                    pc_d          = pc_q + 64'd4;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed test-plan scenarios plus randomized stall/branch/reset traffic against a behavioural model
module tb_instr_fetch_ctrl;
    localparam int unsigned MEM_SIZE = 1024;
    localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic chk_en = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] rom [MEM_SIZE/4];
    logic [63:0] m_pc, m_if_pc;
    logic [31:0] m_instr, m_cnt;
    logic        m_valid, m_fault;

    instr_fetch_ctrl_if bus();

    instr_fetch_ctrl #(.MEM_SIZE(MEM_SIZE), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        if (a[1:0] == 2'b00 && a < 64'(MEM_SIZE)) return rom[int'(a >> 2)];
        return a[31:0] ^ 32'h5A5A_A5A5;
    endfunction

    assign bus.imem_instr = rom_word(bus.imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the fault flag doubles as "halted", since only a fault can halt
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_if_pc = 64'h0; m_instr = 32'h0; m_cnt = 32'h0; m_fault = 1'b0;
        end else if (!m_fault) begin
            if (bus.br_taken) begin
                m_pc = bus.br_target;
                m_valid = 1'b0;
            end else if (!bus.stall) begin
                if (BOUNDS && (m_pc % 4 != 0 || m_pc + 3 >= 64'(MEM_SIZE))) begin
                    m_fault = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_if_pc = m_pc;
                    m_instr = rom_word(m_pc);
                    m_valid = 1'b1;
                    m_pc = m_pc + 4;
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("if_valid", 64'(bus.if_valid), 64'(m_valid));
            chk("if_pc", bus.if_pc, m_if_pc);
            chk("if_instr", 64'(bus.if_instr), 64'(m_instr));
            chk("fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
            chk("fault", 64'(bus.fault), 64'(m_fault));
        end
    end

    task automatic drive(input logic s, input logic b, input logic [63:0] t);
        bus.stall = s;
        bus.br_taken = b;
        bus.br_target = t;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges, checked before any further edge
    task automatic do_reset();
        bus.stall = 1'b0;
        bus.br_taken = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_addr", bus.imem_addr, RESET_PC);
        chk("async_rst_valid", 64'(bus.if_valid), 64'd0);
        chk("async_rst_count", 64'(bus.fetch_count), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_SIZE / 4); i++) rom[i] = $urandom;
        rom[0] = 32'hAAAA_0000; rom[1] = 32'hBBBB_0004; rom[2] = 32'hCCCC_0008; rom[3] = 32'hDDDD_000C;
        bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = 64'h0;
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        chk("rst_addr", bus.imem_addr, RESET_PC);
        chk("rst_count", 64'(bus.fetch_count), 64'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        drive(0, 0, 0);
        chk("first_pc", bus.if_pc, 64'h0);
        chk("first_instr", 64'(bus.if_instr), 64'hAAAA_0000);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("third_pc", bus.if_pc, 64'h8);
        chk("third_instr", 64'(bus.if_instr), 64'hCCCC_0008);
        repeat (3) drive(1, 0, 0);
        chk("stall_pc", bus.if_pc, 64'h8);
        chk("stall_addr", bus.imem_addr, 64'hC);
        chk("stall_count", 64'(bus.fetch_count), 64'd3);
        drive(0, 0, 0);
        chk("fourth_pc", bus.if_pc, 64'hC);
        chk("fourth_instr", 64'(bus.if_instr), 64'hDDDD_000C);
        chk("fourth_count", 64'(bus.fetch_count), 64'd4);
        drive(1, 1, 64'h40);
        chk("br_stall_valid", 64'(bus.if_valid), 64'd0);
        chk("br_stall_addr", bus.imem_addr, 64'h40);
        chk("br_stall_count", 64'(bus.fetch_count), 64'd4);
        drive(0, 0, 0);
        chk("br_target_pc", bus.if_pc, 64'h40);
        chk("br_target_valid", 64'(bus.if_valid), 64'd1);
        chk("br_target_instr", 64'(bus.if_instr), 64'(rom[16]));
        drive(0, 1, 64'h3FE);
        drive(0, 0, 0);
        if (BOUNDS) begin
            chk("mis_fault", 64'(bus.fault), 64'd1);
            chk("mis_valid", 64'(bus.if_valid), 64'd0);
            chk("mis_addr", bus.imem_addr, 64'h3FE);
            drive(0, 1, 64'h80);
            drive(1, 0, 0);
            drive(0, 0, 0);
            chk("halt_addr", bus.imem_addr, 64'h3FE);
            chk("halt_fault", 64'(bus.fault), 64'd1);
            do_reset();
        end else begin
            chk("mis_nofault", 64'(bus.fault), 64'd0);
            chk("mis_valid", 64'(bus.if_valid), 64'd1);
            chk("mis_pc", bus.if_pc, 64'h3FE);
            chk("mis_instr", 64'(bus.if_instr), 64'h3FE ^ 64'h5A5A_A5A5);
        end
        drive(0, 1, 64'h3FC);
        drive(0, 0, 0);
        chk("last_word_pc", bus.if_pc, 64'h3FC);
        chk("last_word_valid", 64'(bus.if_valid), 64'd1);
        drive(0, 0, 0);
        chk("past_end_fault", 64'(bus.fault), 64'(BOUNDS));
        chk("past_end_valid", 64'(bus.if_valid), 64'(!BOUNDS));
        do_reset();
        drive(0, 0, 0);
        chk("post_rst_pc", bus.if_pc, RESET_PC);
        chk("post_rst_valid", 64'(bus.if_valid), 64'd1);
        chk("post_rst_count", 64'(bus.fetch_count), 64'd1);
        for (int n = 0; n < 3000; n++) begin
            logic [63:0] t;
            t = ($urandom_range(0, 9) < 8) ? 64'($urandom_range(0, 255) * 4) : 64'($urandom_range(0, 2047));
            if ($urandom_range(0, 199) == 0) do_reset();
            else drive($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 15, t);
        end
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
